// File: rtl/alu_uart_if_if.sv
// Bundle of UART-side and ALU-side signals between the frame controller and its
// neighbours; slave modport is the controller view, master the surrounding logic.
interface alu_uart_if_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_operation_code;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_alu_overflow;
    logic               i_alu_zero;
    logic               o_busy;

    modport slave (
        input  i_rx_data,
        input  i_rx_done,
        input  i_tx_done,
        output o_tx_data,
        output o_tx_start,
        output o_data_a,
        output o_data_b,
        output o_operation_code,
        input  i_alu_result,
        input  i_alu_overflow,
        input  i_alu_zero,
        output o_busy
    );

    modport master (
        output i_rx_data,
        output i_rx_done,
        output i_tx_done,
        input  o_tx_data,
        input  o_tx_start,
        input  o_data_a,
        input  o_data_b,
        input  o_operation_code,
        output i_alu_result,
        output i_alu_overflow,
        output i_alu_zero,
        input  o_busy
    );
endinterface

// File: rtl/alu_uart_if.sv
// Collects operand A, operand B and opcode bytes from a UART, runs the ALU and sends the
// result back; defining ALU_IF_FLAGS_EN adds a second reply byte {overflow, zero}.
module alu_uart_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input logic           i_clk,
    input logic           i_rst_n,
    alu_uart_if_if.slave  bus
);

    localparam logic [2:0] StWaitA   = 3'd0;
    localparam logic [2:0] StWaitB   = 3'd1;
    localparam logic [2:0] StWaitOp  = 3'd2;
    localparam logic [2:0] StExec    = 3'd3;
    localparam logic [2:0] StSendRes = 3'd4;
    localparam logic [2:0] StWaitRes = 3'd5;
`ifdef ALU_IF_FLAGS_EN
    localparam logic [2:0] StSendFlg = 3'd6;
    localparam logic [2:0] StWaitFlg = 3'd7;
`endif

    logic [2:0]         state_q, state_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] res_q, res_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
`ifdef ALU_IF_FLAGS_EN
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
`else
    logic               unused_flags;
    assign unused_flags = bus.i_alu_overflow ^ bus.i_alu_zero;
`endif

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        res_d      = res_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
`ifdef ALU_IF_FLAGS_EN
        ovf_d      = ovf_q;
        zero_d     = zero_q;
`endif
        case (state_q)
            StWaitA: begin
                if (bus.i_rx_done) begin
                    data_a_d = bus.i_rx_data;
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                if (bus.i_rx_done) begin
                    data_b_d = bus.i_rx_data;
                    state_d  = StWaitOp;
                end
            end
            StWaitOp: begin
                if (bus.i_rx_done) begin
                    op_d    = bus.i_rx_data[NB_OP-1:0];
                    state_d = StExec;
                end
            end
            StExec: begin
                res_d   = bus.i_alu_result;
`ifdef ALU_IF_FLAGS_EN
                ovf_d   = bus.i_alu_overflow;
                zero_d  = bus.i_alu_zero;
`endif
                state_d = StSendRes;
            end
            StSendRes: begin
                tx_data_d  = res_q;
                tx_start_d = 1'b1;
                state_d    = StWaitRes;
            end
            StWaitRes: begin
                // Bytes arriving while a reply is outstanding are dropped.
                if (bus.i_tx_done) begin
`ifdef ALU_IF_FLAGS_EN
                    state_d = StSendFlg;
`else
                    state_d = StWaitA;
`endif
                end
            end
`ifdef ALU_IF_FLAGS_EN
            StSendFlg: begin
                tx_data_d  = {{(NB_DATA-2){1'b0}}, ovf_q, zero_q};
                tx_start_d = 1'b1;
                state_d    = StWaitFlg;
            end
            StWaitFlg: begin
                if (bus.i_tx_done) begin
                    state_d = StWaitA;
                end
            end
`endif
            default: begin
                state_d = StWaitA;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StWaitA;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            res_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
`ifdef ALU_IF_FLAGS_EN
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
`ifdef ALU_IF_FLAGS_EN
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
`endif
        end
    end

    assign bus.o_data_a         = data_a_q;
    assign bus.o_data_b         = data_b_q;
    assign bus.o_operation_code = op_q;
    assign bus.o_tx_data        = tx_data_q;
    assign bus.o_tx_start       = tx_start_q;
    assign bus.o_busy           = (state_q != StWaitA);

endmodule

// File: tb/tb_alu_uart_if.sv
// Scoreboard bench for alu_uart_if: frames are pushed as expected reply bytes, a monitor
// pops and compares on each o_tx_start; a simple responder answers with i_tx_done.
module tb_alu_uart_if;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] exp_q[$];

    alu_uart_if_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_uart_if #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: overflow is carry-out / borrow.
    always_comb begin
        logic [8:0] wide;
        wide = 9'd0;
        case (bus.o_operation_code)
            6'h20:   wide = {1'b0, bus.o_data_a} + {1'b0, bus.o_data_b};
            6'h22:   wide = {1'b0, bus.o_data_a} - {1'b0, bus.o_data_b};
            6'h24:   wide = {1'b0, bus.o_data_a & bus.o_data_b};
            6'h25:   wide = {1'b0, bus.o_data_a | bus.o_data_b};
            default: wide = 9'd0;
        endcase
        bus.i_alu_result   = wide[7:0];
        bus.i_alu_overflow = wide[8];
        bus.i_alu_zero     = (wide[7:0] == 8'h00);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop, single-cycle start and data stability while pending.
    initial begin
        logic       prev_start;
        logic       pending;
        logic [7:0] held;
        prev_start = 1'b0;
        pending    = 1'b0;
        held       = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending    = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (bus.o_tx_start) begin
                    check("tx_start_single", {31'd0, prev_start}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected", {24'd0, bus.o_tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, exp_q.pop_front()});
                    end
                    pending = 1'b1;
                    held    = bus.o_tx_data;
                end else if (pending) begin
                    check("tx_data_stable", {24'd0, bus.o_tx_data}, {24'd0, held});
                end
                if (bus.i_tx_done) pending = 1'b0;
                prev_start = bus.o_tx_start;
            end
        end
    end

    // Transmitter model: completes four cycles after each start.
    initial begin
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                repeat (4) @(posedge clk);
                #1 bus.i_tx_done = 1'b1;
                @(posedge clk);
                #1 bus.i_tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(posedge clk);
        #1 bus.i_rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.o_busy && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("busy_release", {31'd0, bus.o_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] res, input logic [7:0] flg,
                             input bit inject);
        exp_q.push_back(res);
`ifdef ALU_IF_FLAGS_EN
        exp_q.push_back(flg);
`else
        if (flg == 8'hFF) $display("unreachable flag value");
`endif
        send_byte(a);
        send_byte(b);
        send_byte(op);
        @(posedge clk);
        #1 check("latency_early", {31'd0, bus.o_tx_start}, 32'd0);
        @(posedge clk);
        #1 check("latency", {31'd0, bus.o_tx_start}, 32'd1);
        check("busy_in_frame", {31'd0, bus.o_busy}, 32'd1);
        if (inject) begin
            send_byte(8'h80);
            check("dropped_byte_a", {24'd0, bus.o_data_a}, {24'd0, a});
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_data_a", {24'd0, bus.o_data_a}, 32'd0);
        check("rst_data_b", {24'd0, bus.o_data_b}, 32'd0);
        check("rst_opcode", {26'd0, bus.o_operation_code}, 32'd0);
        check("rst_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
        check("rst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);

        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b0);
        check("hold_data_a", {24'd0, bus.o_data_a}, 32'h05);
        check("hold_data_b", {24'd0, bus.o_data_b}, 32'h03);

        run_frame(8'hFF, 8'h01, 8'h20, 8'h00, 8'h03, 1'b0);

        run_frame(8'h03, 8'h05, 8'hE2, 8'hFE, 8'h02, 1'b0);
        check("opcode_trunc", {26'd0, bus.o_operation_code}, 32'h22);

        // Partial frame discarded by reset.
        send_byte(8'h11);
        check("partial_a", {24'd0, bus.o_data_a}, 32'h11);
        check("partial_busy", {31'd0, bus.o_busy}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst2_data_a", {24'd0, bus.o_data_a}, 32'd0);
        check("rst2_opcode", {26'd0, bus.o_operation_code}, 32'd0);
        check("rst2_busy", {31'd0, bus.o_busy}, 32'd0);

        run_frame(8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00, 1'b0);
        check("or_data_a", {24'd0, bus.o_data_a}, 32'h0F);

        run_frame(8'h07, 8'h02, 8'h20, 8'h09, 8'h00, 1'b1);
        check("after_drop_a", {24'd0, bus.o_data_a}, 32'h07);
        check("after_drop_busy", {31'd0, bus.o_busy}, 32'd0);

        run_frame(8'h01, 8'h01, 8'h24, 8'h01, 8'h00, 1'b0);
        check("and_data_b", {24'd0, bus.o_data_b}, 32'h01);

        repeat (10) @(posedge clk);
        #1 check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
